// File: rtl/mips32_mem_arbiter.sv
// rtl/mips32_mem_arbiter.sv - single-port IF/MEM memory arbiter with starvation guard and fetch flush
module mips32_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              if_flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    owner_t     owner;
    logic       owner_we;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       flush_pend;
    logic       starved;

    // Data wins unless fetch has lost STARVE_MAX arbitrations in a row.
    always_comb begin
        starved   = if_req && (starve_cnt == STARVE_LIM);
        d_gnt     = !rst && (state == IDLE) && d_req && !starved;
        if_gnt    = !rst && (state == IDLE) && if_req && !d_gnt;
        mem_en    = if_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
        mem_wdata = rst ? '0 : d_wdata;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            owner_we   <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            flush_pend <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;

            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (d_gnt)
                starve_cnt <= starve_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (mem_en) begin
                        state      <= WAIT;
                        owner      <= d_gnt ? OWN_D : OWN_IF;
                        owner_we   <= d_gnt & d_we;
                        lat_cnt    <= 4'd1;
                        flush_pend <= if_gnt & if_flush;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 4'd1;
                    if (owner == OWN_IF && if_flush)
                        flush_pend <= 1'b1;
                    // Last latency cycle: route read data to the owner and rearm.
                    if (lat_cnt == LAT_LAST) begin
                        state      <= IDLE;
                        owner      <= OWN_NONE;
                        lat_cnt    <= '0;
                        flush_pend <= 1'b0;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            if (!owner_we)
                                d_rdata <= mem_rdata;
                        end else if (!(flush_pend || if_flush)) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb/tb_mips32_mem_arbiter.sv - directed self-checking bench for mips32_mem_arbiter
module tb_mips32_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic              clk1;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_flush;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mips32_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk1(clk1), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_flush(if_flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Fixed-latency memory: 16 words, read data appears MEM_LAT cycles after mem_en.
    logic [DATA_W-1:0] tb_mem [0:15] = '{
        32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3,
        32'h000000A4, 32'hDEADBEEF, 32'h00000066, 32'h000000A7,
        32'h000000A8, 32'h00000909, 32'h000000AA, 32'h000000AB,
        32'h000000AC, 32'h000000AD, 32'h000000AE, 32'h000000AF
    };
    logic [DATA_W-1:0] rd_pipe [0:MEM_LAT-1] = '{default: '0};

    always @(posedge clk1) begin
        if (mem_en && mem_we)
            tb_mem[mem_addr[3:0]] <= mem_wdata;
        rd_pipe[0] <= tb_mem[mem_addr[3:0]];
        for (int i = 1; i < MEM_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk1);
        #2;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset: grants and memory strobes forced low even with requests present
        #1; if_req = 1'b1; d_req = 1'b1; d_wdata = 32'hFFFF_FFFF;
        #1;
        check("rst_if_gnt", 32'(if_gnt), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_rvalid", 32'(if_rvalid), 0);
        check("rst_d_rvalid", 32'(d_rvalid), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        next_cycle(); if_req = 1'b0; d_req = 1'b0; d_wdata = '0;
        next_cycle(); rst = 1'b0;
        next_cycle();

        // Single fetch
        next_cycle(); if_req = 1'b1; if_addr = 10'd5; #1;
        check("f_if_gnt", 32'(if_gnt), 1);
        check("f_d_gnt", 32'(d_gnt), 0);
        check("f_mem_en", 32'(mem_en), 1);
        check("f_mem_addr", 32'(mem_addr), 5);
        check("f_mem_we", 32'(mem_we), 0);
        next_cycle(); if_req = 1'b0; #1;
        check("f_c1_mem_en", 32'(mem_en), 0);
        check("f_c1_rvalid", 32'(if_rvalid), 0);
        next_cycle(); #1;
        check("f_c2_rvalid", 32'(if_rvalid), 0);
        next_cycle(); #1;
        check("f_c3_rvalid", 32'(if_rvalid), 1);
        check("f_c3_rdata", if_rdata, 32'hDEADBEEF);
        next_cycle(); #1;
        check("f_c4_rvalid", 32'(if_rvalid), 0);

        // Simultaneous fetch and load: data first, fetch follows in the rvalid cycle
        next_cycle(); if_req = 1'b1; if_addr = 10'd6; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9; #1;
        check("b_c0_d_gnt", 32'(d_gnt), 1);
        check("b_c0_if_gnt", 32'(if_gnt), 0);
        check("b_c0_mem_addr", 32'(mem_addr), 9);
        next_cycle(); d_req = 1'b0; #1;
        check("b_c1_if_gnt", 32'(if_gnt), 0);
        next_cycle(); #1;
        next_cycle(); #1;
        check("b_c3_d_rvalid", 32'(d_rvalid), 1);
        check("b_c3_d_rdata", d_rdata, 32'h00000909);
        check("b_c3_if_gnt", 32'(if_gnt), 1);
        check("b_c3_mem_addr", 32'(mem_addr), 6);
        next_cycle(); if_req = 1'b0; #1;
        check("b_c4_d_rvalid", 32'(d_rvalid), 0);
        next_cycle(); #1;
        next_cycle(); #1;
        check("b_c6_if_rvalid", 32'(if_rvalid), 1);
        check("b_c6_if_rdata", if_rdata, 32'h00000066);

        // Store then load back the same word
        next_cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 10'd7; d_wdata = 32'h12345678; #1;
        check("s_d_gnt", 32'(d_gnt), 1);
        check("s_mem_we", 32'(mem_we), 1);
        check("s_mem_addr", 32'(mem_addr), 7);
        check("s_mem_wdata", mem_wdata, 32'h12345678);
        next_cycle(); d_req = 1'b0; d_we = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); d_req = 1'b1; d_addr = 10'd7; #1;
        check("s_d_rvalid", 32'(d_rvalid), 1);
        check("s_d_rdata_held", d_rdata, 32'h00000909);
        check("l_d_gnt", 32'(d_gnt), 1);
        check("l_mem_we", 32'(mem_we), 0);
        next_cycle(); d_req = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("l_d_rvalid", 32'(d_rvalid), 1);
        check("l_d_rdata", d_rdata, 32'h12345678);

        // Starvation: data held continuously; fetch forced through after STARVE_MAX losses
        next_cycle(); if_req = 1'b1; if_addr = 10'd5; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) next_cycle();
            if (c == 13) if_req = 1'b0;
            #1;
            check($sformatf("st_d_gnt_c%0d", c), 32'(d_gnt),
                  (c == 0 || c == 3 || c == 6 || c == 9 || c == 15) ? 1 : 0);
            check($sformatf("st_if_gnt_c%0d", c), 32'(if_gnt), (c == 12) ? 1 : 0);
            if (c == 15) begin
                check("st_if_rvalid_c15", 32'(if_rvalid), 1);
                check("st_if_rdata_c15", if_rdata, 32'hDEADBEEF);
            end
        end
        next_cycle(); d_req = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("st_d_rvalid_c18", 32'(d_rvalid), 1);

        // Flush during WAIT; fresh fetch in the would-be rvalid cycle
        next_cycle(); if_req = 1'b1; if_addr = 10'd6; #1;
        check("fl_c0_if_gnt", 32'(if_gnt), 1);
        next_cycle(); if_req = 1'b0; if_flush = 1'b1; #1;
        next_cycle(); if_flush = 1'b0; #1;
        next_cycle(); if_req = 1'b1; if_addr = 10'd3; #1;
        check("fl_c3_if_rvalid", 32'(if_rvalid), 0);
        check("fl_c3_if_rdata", if_rdata, 32'hDEADBEEF);
        check("fl_c3_if_gnt", 32'(if_gnt), 1);
        next_cycle(); if_req = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("fl_c6_if_rvalid", 32'(if_rvalid), 1);
        check("fl_c6_if_rdata", if_rdata, 32'h000000A3);

        // Flush in the grant cycle does not block the grant but kills the response
        next_cycle(); if_req = 1'b1; if_addr = 10'd6; if_flush = 1'b1; #1;
        check("fg_c0_if_gnt", 32'(if_gnt), 1);
        next_cycle(); if_req = 1'b0; if_flush = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("fg_c3_if_rvalid", 32'(if_rvalid), 0);
        check("fg_c3_if_rdata", if_rdata, 32'h000000A3);

        // Reset mid-fetch drops the response
        next_cycle(); if_req = 1'b1; if_addr = 10'd5; #1;
        check("r_c0_if_gnt", 32'(if_gnt), 1);
        next_cycle(); if_req = 1'b0; rst = 1'b1; #1;
        check("r_c1_if_rvalid", 32'(if_rvalid), 0);
        check("r_c1_if_rdata", if_rdata, 0);
        check("r_c1_d_rdata", d_rdata, 0);
        check("r_c1_mem_en", 32'(mem_en), 0);
        next_cycle(); rst = 1'b0;
        for (int c = 2; c < 6; c++) begin
            #1;
            check($sformatf("r_c%0d_if_rvalid", c), 32'(if_rvalid), 0);
            check($sformatf("r_c%0d_if_rdata", c), if_rdata, 0);
            next_cycle();
        end
        if_req = 1'b1; if_addr = 10'd5; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9; #1;
        check("r_post_d_gnt", 32'(d_gnt), 1);
        check("r_post_if_gnt", 32'(if_gnt), 0);
        next_cycle(); d_req = 1'b0; #1;
        next_cycle(); #1;
        next_cycle(); #1;
        check("r_post_d_rvalid", 32'(d_rvalid), 1);
        check("r_post_d_rdata", d_rdata, 32'h00000909);
        check("r_post_if_gnt_c3", 32'(if_gnt), 1);
        next_cycle(); if_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
